// File: rtl/cronometro_regressivo_param.sv
// Shot-clock countdown: whole seconds down from a preset or loaded value, with pause,
// reload, expiry flag, per-second tick and a fixed-length buzzer pulse on reaching zero.
module cronometro_regressivo_param #(
    parameter int TICKS_POR_SEGUNDO = 50_000_000,
    parameter int LARGURA           = 7,
    parameter int VALOR_A           = 14,
    parameter int VALOR_B           = 24,
    parameter int BUZZER_CICLOS     = 50_000_000
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               recarregar,
    input  logic               chaveEscolherCronometro,
    input  logic               chaveParar,
    input  logic               carregar_valor,
    input  logic [LARGURA-1:0] valor_carga,
    output logic [LARGURA-1:0] saida,
    output logic               buzzer,
    output logic               expirado,
    output logic               tick_segundo
);

    localparam int PW = (TICKS_POR_SEGUNDO > 1) ? $clog2(TICKS_POR_SEGUNDO) : 1;
    localparam int BW = (BUZZER_CICLOS > 1) ? $clog2(BUZZER_CICLOS) : 1;

    localparam logic [PW-1:0]      PRESC_MAX = PW'(TICKS_POR_SEGUNDO - 1);
    localparam logic [BW-1:0]      BUZ_INI   = BW'(BUZZER_CICLOS - 1);
    localparam logic [LARGURA-1:0] PRESET_A  = LARGURA'(VALOR_A);
    localparam logic [LARGURA-1:0] PRESET_B  = LARGURA'(VALOR_B);
    localparam logic [LARGURA-1:0] UM        = LARGURA'(1);

    logic [LARGURA-1:0] saida_q, saida_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [BW-1:0]      buz_cnt_q, buz_cnt_d;
    logic               buzzer_q, buzzer_d;
    logic               expirado_q, expirado_d;
    logic               tick_q, tick_d;
    logic [LARGURA-1:0] preset_sel;

    assign preset_sel = chaveEscolherCronometro ? PRESET_B : PRESET_A;

    always_comb begin
        saida_d   = saida_q;
        presc_d   = presc_q;
        buz_cnt_d = buz_cnt_q;
        buzzer_d  = buzzer_q;
        tick_d    = 1'b0;

        // buz_cnt_q holds the remaining high cycles after the current one
        if (buzzer_q) begin
            if (buz_cnt_q == '0) begin
                buzzer_d = 1'b0;
            end else begin
                buz_cnt_d = buz_cnt_q - 1'b1;
            end
        end

        if (recarregar) begin
            saida_d   = preset_sel;
            presc_d   = '0;
            buzzer_d  = 1'b0;
            buz_cnt_d = '0;
        end else if (carregar_valor) begin
            saida_d   = valor_carga;
            presc_d   = '0;
            buzzer_d  = 1'b0;
            buz_cnt_d = '0;
        end else if (!chaveParar && (saida_q != '0)) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                saida_d = saida_q - 1'b1;
                tick_d  = 1'b1;
                if (saida_q == UM) begin
                    buzzer_d  = 1'b1;
                    buz_cnt_d = BUZ_INI;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        expirado_d = (saida_d == '0);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            saida_q    <= PRESET_A;
            presc_q    <= '0;
            buz_cnt_q  <= '0;
            buzzer_q   <= 1'b0;
            tick_q     <= 1'b0;
            expirado_q <= (PRESET_A == '0);
        end else begin
            saida_q    <= saida_d;
            presc_q    <= presc_d;
            buz_cnt_q  <= buz_cnt_d;
            buzzer_q   <= buzzer_d;
            tick_q     <= tick_d;
            expirado_q <= expirado_d;
        end
    end

    assign saida        = saida_q;
    assign buzzer       = buzzer_q;
    assign expirado     = expirado_q;
    assign tick_segundo = tick_q;

endmodule

// File: doc/cronometro_regressivo_param.md
# cronometro_regressivo_param

Parametrised shot-clock countdown for the basketball scoreboard. Counts whole seconds down from one of two selectable presets, or from an arbitrary loaded value, with pause, reload and a timed buzzer pulse on expiry. Supersedes the fixed 14/24 pair of countdowns: one counter, generic width, prescaler and buzzer length, plus expiry and per-second tick outputs. Feeds the display decoder and the buzzer driver.

## Interface
Parameters:
- TICKS_POR_SEGUNDO, 50_000_000, clock cycles per counted second (≥2)
- LARGURA, 7, width of the seconds value
- VALOR_A, 14, preset selected when chaveEscolherCronometro=0 (< 2^LARGURA)
- VALOR_B, 24, preset selected when chaveEscolherCronometro=1 (< 2^LARGURA)
- BUZZER_CICLOS, 50_000_000, buzzer pulse length in clock cycles (≥1)

Ports:
- clock_in  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- recarregar  in  1  level; while high, counter held at selected preset
- chaveEscolherCronometro  in  1  preset select: 0 → VALOR_A, 1 → VALOR_B
- chaveParar  in  1  1 = paused, 0 = running
- carregar_valor  in  1  load valor_carga into counter
- valor_carga  in  LARGURA  arbitrary load value
- saida  out  LARGURA  current seconds remaining
- buzzer  out  1  high for BUZZER_CICLOS cycles after expiry
- expirado  out  1  high while saida == 0
- tick_segundo  out  1  one-cycle pulse on each decrement

## Operation
- State: seconds register (LARGURA), prescaler (0..TICKS_POR_SEGUNDO-1), buzzer counter. All outputs registered.
- Reset: saida=VALOR_A, prescaler=0, buzzer=0, tick_segundo=0, expirado=(VALOR_A==0).
- Per-edge priority: reset > recarregar > carregar_valor > countdown.
- recarregar high: saida ← selected preset, prescaler ← 0, buzzer ← 0 (cancels an active pulse), tick_segundo=0.
- carregar_valor high (recarregar low): saida ← valor_carga, prescaler ← 0, buzzer ← 0.
- Countdown runs only when chaveParar=0 and saida>0. Prescaler increments each cycle. At TICKS_POR_SEGUNDO-1 it wraps to 0, saida decrements by 1 and tick_segundo pulses.
- Paused: prescaler and saida hold. A partial second resumes from where it stopped. No tick is generated.
- Expiry (saida 1 → 0): buzzer rises on the same edge and stays high exactly BUZZER_CICLOS cycles, then falls. saida stays at 0, with no wrap or underflow, until a reload or load.
- At saida==0 the prescaler holds at 0. Pause has no effect on a buzzer pulse already in progress.
- Changing chaveEscolherCronometro while counting has no effect until the next recarregar.
- Loading 0 via carregar_valor: saida=0, expirado=1, no buzzer (buzzer only on a 1→0 countdown transition).

## Timing
- Reload/load latency: 1 cycle. saida shows the new value on the edge after the input is sampled high.
- First decrement after reload/load with chaveParar=0: exactly TICKS_POR_SEGUNDO cycles after the loading edge.
- Full countdown from N to 0: N×TICKS_POR_SEGUNDO running cycles.
- tick_segundo: high for exactly the one cycle in which the new saida value first appears.
- expirado tracks saida on the same edge as saida (registered, not combinational).
- Reset applied mid-count or mid-buzzer: all state takes reset values on that edge.

## Test plan
Test-plan runs use TICKS_POR_SEGUNDO=4, BUZZER_CICLOS=3, LARGURA=5, VALOR_A=14, VALOR_B=24.
- Reset, then recarregar=1 for one cycle with select=1 and chaveParar=0 → saida=24. First tick after 4 cycles, saida=23. tick_segundo pulses every 4 cycles.
- Load 2 via carregar_valor and run → saida 2→1→0 at cycles 4 and 8. buzzer high cycles 8–10, low at 11. expirado=1 from cycle 8. saida stays 0 for 20 more cycles.
- Select=0 and reload → saida=14. Run 6 cycles, pause for 10 cycles → saida=13 and prescaler frozen. Resume → saida=12 exactly 2 running cycles later.
- recarregar and carregar_valor both high with valor_carga=5 and select=1 → saida=24 (recarregar wins). reset together with recarregar → saida=14.
- Reload during the buzzer pulse → buzzer drops on the next edge and saida=preset. Then carregar_valor with 0 → expirado=1, buzzer stays 0.
- Toggle select mid-count (saida=20) → count continues 20→19 unchanged. Next recarregar loads the newly selected preset.
